uart_dmi_framer: RTL and testbench
==================================

// Module: uart_dmi_framer
// PURPOSE
// Upstream neighbour of the DMI adapter in the UART debug transport. After the command decoder
// pulses START_I, collects a little-endian DMI request byte frame from the UART RX stream and
// hands it to the adapter over the write handshake. Then collects the adapter's response over the
// read handshake and serializes it little-endian onto the UART TX stream.
// PARAMETERS
// DMI_WIDTH     41  request/response width: addr[40:34] data[33:2] op/err[1:0]
// NBYTES        6   bytes per frame = ceil(DMI_WIDTH/8)
// RESP_TIMEOUT  256 max cycles in RESP before a synthetic busy response (>=2)
// PORTS
// CLK_I              in   1          clock
// RST_I              in   1          synchronous reset, active-high
// START_I            in   1          pulse: next NBYTES RX bytes form a DMI request
// ABORT_I            in   1          drop frame in progress (honoured in RX/TX only)
// BUSY_O             out  1          high in every state except IDLE
// RX_DATA_I          in   8          UART RX byte
// RX_VALID_I         in   1          RX byte valid
// RX_READY_O         out  1          RX byte accepted when VALID&READY
// TX_DATA_O          out  8          UART TX byte
// TX_VALID_O         out  1          TX byte valid
// TX_READY_I         in   1          TX byte taken when VALID&READY
// DMI_WRITE_DATA_O   out  DMI_WIDTH  assembled request to adapter
// DMI_WRITE_VALID_O  out  1          request valid
// DMI_WRITE_READY_I  in   1          adapter accepted request (1-cycle pulse)
// DMI_READ_READY_O   out  1          framer wants the response
// DMI_READ_DATA_I    in   DMI_WIDTH  adapter response
// DMI_READ_VALID_I   in   1          response valid
// BEHAVIOUR
// - All state is synchronous. RST_I is checked first and overrides everything, including
//   mid-operation: state IDLE, every output 0, shift reg 0, byte/timeout counters 0.
// - FSM states: IDLE, RX, REQ, SETTLE, RESP, TX.
// - IDLE: on START_I go to RX with byte_idx=0. Otherwise all handshakes are low.
// - RX: RX_READY_O=1. Each accepted byte is written to shreg[8*byte_idx +: 8] and byte_idx
//   increments. The NBYTES*8-DMI_WIDTH pad bits of the last byte are discarded. On acceptance of
//   byte NBYTES-1, go to REQ and clear byte_idx. DMI_WRITE_VALID_O is high on the next cycle.
// - REQ: hold DMI_WRITE_VALID_O=1 with stable data until a cycle with DMI_WRITE_READY_I=1. In
//   that cycle go to SETTLE; VALID is 0 on the following cycle. VALID must not linger, because
//   the adapter waits for VALID low before re-arming.
// - SETTLE: one cycle with DMI_READ_READY_O=0 so that a stale READ_VALID is never sampled.
//   Then go to RESP with the timeout counter cleared.
// - RESP: DMI_READ_READY_O=1; the timeout counter increments each cycle.
//   - First cycle with DMI_READ_VALID_I=1: capture DMI_READ_DATA_I into shreg, go to TX. READY
//     drops on the next cycle.
//   - Counter reaching RESP_TIMEOUT-1 with no VALID: load shreg = {req addr, 32'h0, 2'b11}
//     (DMIBusy) and go to TX.
//   - VALID and timeout in the same cycle: the real response wins.
// - TX: TX_DATA_O = shreg[8*byte_idx +: 8], with pad bits forced to 0; TX_VALID_O=1. byte_idx
//   increments on VALID&READY. After byte NBYTES-1 is taken, go to IDLE. TX_VALID_O is
//   registered and rises the cycle after entry.
// - START_I outside IDLE is ignored.
// - ABORT_I in RX or TX: go to IDLE next cycle, clear byte_idx, drop VALID/READY.
//   - ABORT_I in REQ/SETTLE/RESP is ignored, because an in-flight DMI op must complete or time out.
//   - ABORT_I and a handshake in the same cycle: ABORT wins and the byte is not counted.
// - BUSY_O = (state != IDLE), registered with the state.
// - Counter widths: byte_idx $clog2(NBYTES); timeout $clog2(RESP_TIMEOUT). No wrap inside a frame.
// TESTING
// - Write: START_I, RX 06 00 00 00 40 00 -> WRITE_DATA 41'h40_0000_0006 held until READY pulse.
//   Model returns 41'h40_0000_0004 -> TX 04 00 00 00 40 00, then BUSY_O=0.
// - Read: RX 01 00 00 00 44 00 -> WRITE_DATA 41'h44_0000_0001. Model returns
//   41'h44_DEAD_BEEF<<2 -> TX bytes match LSB-first, last byte bits[7:1]=0.
// - Timeout (RESP_TIMEOUT=16): model never asserts READ_VALID -> after 16 RESP cycles TX
//   03 00 00 00 44 00 (DMIBusy); READ_READY low afterwards.
// - Backpressure: RX_VALID gapped randomly, TX_READY low for 5 cycles per byte -> identical
//   frames; WRITE_VALID data is stable while READY is low.
// - Abort/restart: ABORT_I after 3 RX bytes -> IDLE, no WRITE_VALID. Next START_I + full frame
//   -> correct request. START_I during TX -> ignored.
// - Reset mid-RESP: RST_I high 1 cycle -> all outputs 0 the next cycle, state IDLE; a late
//   READ_VALID is ignored.

Source files
------------

// File: rtl/uart_dmi_framer.sv
// UART byte framer for DMI requests/responses.
// Collects LE request bytes, hands off to adapter, serializes reply.
module uart_dmi_framer #(
  parameter int DMI_WIDTH    = 41,
  parameter int NBYTES       = (DMI_WIDTH + 7) / 8,
  parameter int RESP_TIMEOUT = 256
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 START_I,
  input  logic                 ABORT_I,
  output logic                 BUSY_O,
  input  logic [7:0]           RX_DATA_I,
  input  logic                 RX_VALID_I,
  output logic                 RX_READY_O,
  output logic [7:0]           TX_DATA_O,
  output logic                 TX_VALID_O,
  input  logic                 TX_READY_I,
  output logic [DMI_WIDTH-1:0] DMI_WRITE_DATA_O,
  output logic                 DMI_WRITE_VALID_O,
  input  logic                 DMI_WRITE_READY_I,
  output logic                 DMI_READ_READY_O,
  input  logic [DMI_WIDTH-1:0] DMI_READ_DATA_I,
  input  logic                 DMI_READ_VALID_I
);

  localparam int SW       = NBYTES * 8;
  localparam int BW       = $clog2(NBYTES);
  localparam int TW       = $clog2(RESP_TIMEOUT);
  localparam int ADDR_LSB = 34;

  // Pad bits above DMI_WIDTH are always held at zero in the shift reg
  localparam logic [SW-1:0] MASK     = {SW{1'b1}} >> (SW - DMI_WIDTH);
  localparam logic [BW-1:0] LAST     = BW'(NBYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_REQ,
    S_SETTLE,
    S_RESP,
    S_TX
  } state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [SW-1:0]        shreg_q, shreg_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [DMI_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                 rd_ready_q, rd_ready_d;
  logic                 busy_q, busy_d;

  // Next-state, counters, shift reg and registered output values
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    shreg_d = shreg_q;
    unique case (state_q)
      S_IDLE: begin
        if (START_I) begin
          state_d = S_RX;
          idx_d   = '0;
        end
      end
      S_RX: begin
        if (ABORT_I) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (RX_VALID_I && rx_ready_q) begin
          shreg_d = ((shreg_q & ~(SW'(8'hFF) << {idx_q, 3'b000}))
                    | (SW'(RX_DATA_I) << {idx_q, 3'b000})) & MASK;
          if (idx_q == LAST) begin
            state_d = S_REQ;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_REQ: begin
        if (DMI_WRITE_READY_I) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d = S_RESP;
        tmo_d   = '0;
      end
      S_RESP: begin
        if (DMI_READ_VALID_I) begin
          shreg_d = SW'(DMI_READ_DATA_I);
          state_d = S_TX;
          idx_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          // Synthetic DMIBusy echoing the request address
          shreg_d = '0;
          shreg_d[DMI_WIDTH-1:ADDR_LSB] = shreg_q[DMI_WIDTH-1:ADDR_LSB];
          shreg_d[1:0] = 2'b11;
          state_d = S_TX;
          idx_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_TX: begin
        if (ABORT_I) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (TX_READY_I && tx_valid_q) begin
          if (idx_q == LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    rx_ready_d = (state_d == S_RX);
    wr_valid_d = (state_d == S_REQ);
    wr_data_d  = wr_valid_d ? shreg_d[DMI_WIDTH-1:0] : '0;
    rd_ready_d = (state_d == S_RESP);
    tx_valid_d = (state_d == S_TX);
    tx_data_d  = tx_valid_d ? 8'(shreg_d >> {idx_d, 3'b000}) : 8'h00;
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tmo_q      <= '0;
      shreg_q    <= '0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      rd_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      shreg_q    <= shreg_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      rd_ready_q <= rd_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign BUSY_O            = busy_q;
  assign RX_READY_O        = rx_ready_q;
  assign TX_DATA_O         = tx_data_q;
  assign TX_VALID_O        = tx_valid_q;
  assign DMI_WRITE_DATA_O  = wr_data_q;
  assign DMI_WRITE_VALID_O = wr_valid_q;
  assign DMI_READ_READY_O  = rd_ready_q;

endmodule

// File: tb/tb_uart_dmi_framer.sv
// Directed bench for uart_dmi_framer.
// Hand-computed frames, immediate-assertion checks.
module tb_uart_dmi_framer;

  logic        CLK_I;
  logic        RST_I;
  logic        START_I;
  logic        ABORT_I;
  logic        BUSY_O;
  logic [7:0]  RX_DATA_I;
  logic        RX_VALID_I;
  logic        RX_READY_O;
  logic [7:0]  TX_DATA_O;
  logic        TX_VALID_O;
  logic        TX_READY_I;
  logic [40:0] DMI_WRITE_DATA_O;
  logic        DMI_WRITE_VALID_O;
  logic        DMI_WRITE_READY_I;
  logic        DMI_READ_READY_O;
  logic [40:0] DMI_READ_DATA_I;
  logic        DMI_READ_VALID_I;

  int passed = 0;
  int total  = 0;
  int n;

  uart_dmi_framer #(
    .DMI_WIDTH(41),
    .NBYTES(6),
    .RESP_TIMEOUT(16)
  ) dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .START_I(START_I),
    .ABORT_I(ABORT_I),
    .BUSY_O(BUSY_O),
    .RX_DATA_I(RX_DATA_I),
    .RX_VALID_I(RX_VALID_I),
    .RX_READY_O(RX_READY_O),
    .TX_DATA_O(TX_DATA_O),
    .TX_VALID_O(TX_VALID_O),
    .TX_READY_I(TX_READY_I),
    .DMI_WRITE_DATA_O(DMI_WRITE_DATA_O),
    .DMI_WRITE_VALID_O(DMI_WRITE_VALID_O),
    .DMI_WRITE_READY_I(DMI_WRITE_READY_I),
    .DMI_READ_READY_O(DMI_READ_READY_O),
    .DMI_READ_DATA_I(DMI_READ_DATA_I),
    .DMI_READ_VALID_I(DMI_READ_VALID_I)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    chk(tag, 64'({BUSY_O, RX_READY_O, TX_VALID_O, TX_DATA_O,
                  DMI_WRITE_VALID_O, DMI_WRITE_DATA_O,
                  DMI_READ_READY_O}), 64'(0));
  endtask

  task automatic start_pulse();
    START_I = 1'b1;
    tick();
    START_I = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    if (gappy) repeat ($urandom_range(0, 3)) tick();
    RX_DATA_I  = b;
    RX_VALID_I = 1'b1;
    for (int t = 0; t < 50 && !RX_READY_O; t++) tick();
    tick();
    RX_VALID_I = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f, input bit gappy);
    for (int i = 0; i < 6; i++) send_byte(f[8*i +: 8], gappy);
  endtask

  task automatic take_write(input logic [40:0] exp, input int hold);
    for (int t = 0; t < 50 && !DMI_WRITE_VALID_O; t++) tick();
    chk("wr_valid", 64'(DMI_WRITE_VALID_O), 64'(1));
    chk("wr_data", 64'(DMI_WRITE_DATA_O), 64'(exp));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("wr_hold_valid", 64'(DMI_WRITE_VALID_O), 64'(1));
      chk("wr_hold_data", 64'(DMI_WRITE_DATA_O), 64'(exp));
    end
    DMI_WRITE_READY_I = 1'b1;
    tick();
    DMI_WRITE_READY_I = 1'b0;
    chk("wr_valid_drop", 64'(DMI_WRITE_VALID_O), 64'(0));
    chk("settle_rd_ready", 64'(DMI_READ_READY_O), 64'(0));
  endtask

  task automatic respond(input logic [40:0] d, input int delay);
    for (int t = 0; t < 50 && !DMI_READ_READY_O; t++) tick();
    chk("rd_ready", 64'(DMI_READ_READY_O), 64'(1));
    repeat (delay) tick();
    DMI_READ_DATA_I  = d;
    DMI_READ_VALID_I = 1'b1;
    tick();
    DMI_READ_VALID_I = 1'b0;
    chk("rd_ready_drop", 64'(DMI_READ_READY_O), 64'(0));
    chk("tx_valid_rise", 64'(TX_VALID_O), 64'(1));
  endtask

  task automatic recv_frame(input logic [47:0] f, input int stall);
    for (int i = 0; i < 6; i++) begin
      for (int t = 0; t < 50 && !TX_VALID_O; t++) tick();
      repeat (stall) tick();
      chk($sformatf("tx_valid%0d", i), 64'(TX_VALID_O), 64'(1));
      chk($sformatf("tx_byte%0d", i), 64'(TX_DATA_O), 64'(f[8*i +: 8]));
      TX_READY_I = 1'b1;
      tick();
      TX_READY_I = 1'b0;
    end
    chk("tx_done_busy", 64'(BUSY_O), 64'(0));
    chk("tx_done_valid", 64'(TX_VALID_O), 64'(0));
  endtask

  initial begin
    RST_I = 1'b1;
    START_I = 1'b0;
    ABORT_I = 1'b0;
    RX_DATA_I = '0;
    RX_VALID_I = 1'b0;
    TX_READY_I = 1'b0;
    DMI_WRITE_READY_I = 1'b0;
    DMI_READ_DATA_I = '0;
    DMI_READ_VALID_I = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    RST_I = 1'b0;
    tick();
    check_idle("idle");

    // write request, ABORT ignored in RESP
    start_pulse();
    chk("rx_ready", 64'(RX_READY_O), 64'(1));
    chk("busy", 64'(BUSY_O), 64'(1));
    send_frame(48'h00_40_00_00_00_06, 1'b0);
    take_write(41'h40_0000_0006, 3);
    tick();
    ABORT_I = 1'b1;
    tick();
    ABORT_I = 1'b0;
    chk("resp_abort_busy", 64'(BUSY_O), 64'(1));
    chk("resp_abort_rdy", 64'(DMI_READ_READY_O), 64'(1));
    respond(41'h40_0000_0004, 2);
    recv_frame(48'h00_40_00_00_00_04, 0);

    // read request
    start_pulse();
    send_frame(48'h00_44_00_00_00_01, 1'b0);
    take_write(41'h44_0000_0001, 0);
    respond(41'h113_7AB6_FBBC, 0);
    recv_frame(48'h01_13_7A_B6_FB_BC, 0);

    // response timeout -> DMIBusy
    start_pulse();
    send_frame(48'h00_44_00_00_00_01, 1'b0);
    take_write(41'h44_0000_0001, 0);
    for (int t = 0; t < 50 && !DMI_READ_READY_O; t++) tick();
    n = 0;
    while (DMI_READ_READY_O && n < 100) begin
      n++;
      tick();
    end
    chk("tmo_cycles", 64'(n), 64'(16));
    chk("tmo_tx_valid", 64'(TX_VALID_O), 64'(1));
    recv_frame(48'h00_44_00_00_00_03, 0);
    chk("tmo_rd_ready", 64'(DMI_READ_READY_O), 64'(0));

    // backpressure, pad bits of last RX byte dropped
    start_pulse();
    send_frame(48'hFF_FF_12_34_56_78, 1'b1);
    take_write(41'h1FF_1234_5678, 4);
    respond(41'h155_AAAA_5555, 1);
    recv_frame(48'h01_55_AA_AA_55_55, 5);

    // abort after 3 bytes
    start_pulse();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    ABORT_I = 1'b1;
    RX_DATA_I = 8'h44;
    RX_VALID_I = 1'b1;
    tick();
    ABORT_I = 1'b0;
    RX_VALID_I = 1'b0;
    chk("abort_busy", 64'(BUSY_O), 64'(0));
    chk("abort_rx_ready", 64'(RX_READY_O), 64'(0));
    repeat (3) tick();
    chk("abort_no_wr", 64'(DMI_WRITE_VALID_O), 64'(0));

    // restart, START during TX ignored
    start_pulse();
    send_frame(48'h00_08_00_00_00_02, 1'b0);
    take_write(41'h08_0000_0002, 0);
    respond(41'h08_0000_0000, 0);
    START_I = 1'b1;
    tick();
    START_I = 1'b0;
    chk("tx_start_busy", 64'(BUSY_O), 64'(1));
    chk("tx_start_rx", 64'(RX_READY_O), 64'(0));
    recv_frame(48'h00_08_00_00_00_00, 1);
    repeat (2) tick();
    chk("tx_start_after", 64'(BUSY_O), 64'(0));

    // reset in RESP, late READ_VALID ignored
    start_pulse();
    send_frame(48'h00_40_00_00_00_06, 1'b0);
    take_write(41'h40_0000_0006, 0);
    for (int t = 0; t < 50 && !DMI_READ_READY_O; t++) tick();
    chk("pre_rst_rdy", 64'(DMI_READ_READY_O), 64'(1));
    RST_I = 1'b1;
    tick();
    check_idle("rst_mid");
    RST_I = 1'b0;
    DMI_READ_DATA_I = 41'h40_0000_0004;
    DMI_READ_VALID_I = 1'b1;
    repeat (2) tick();
    DMI_READ_VALID_I = 1'b0;
    check_idle("late_valid");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
